// File: rtl/sync_frame_tx.sv
// rtl/sync_frame_tx.sv - serial frame transmitter: sync preamble, MSB-first payload, idle gap
module sync_frame_tx #(
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          SYNC_LEN = 4,
  parameter logic [SYNC_LEN-1:0]  SYNC_PAT = 4'b0011,
  parameter int unsigned          GAP_BITS = 2,
  parameter logic                 IDLE_LVL = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              bit_en_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              w_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [4:0]        bit_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_e;

  localparam logic [4:0] SYNC_LAST = 5'(SYNC_LEN - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);
  localparam logic [4:0] GAP_LAST  = (GAP_BITS > 0) ? 5'(GAP_BITS - 1) : 5'd0;

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [SYNC_LEN-1:0] sync_q, sync_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                w_q, w_d;
  logic                done_q, done_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      sync_q  <= '0;
      data_q  <= '0;
      w_q     <= IDLE_LVL;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      w_q     <= w_d;
      done_q  <= done_d;
    end
  end

  // w_q is the bit on the line; sync_q/data_q hold the bits still to be sent, next one at the MSB
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = sync_q;
    data_d  = data_q;
    w_d     = w_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_d   = IDLE_LVL;
        cnt_d = 5'd0;
        if (load_valid_i) begin
          state_d = S_SYNC;
          data_d  = load_data_i;
          sync_d  = SYNC_PAT << 1;
          w_d     = SYNC_PAT[SYNC_LEN-1];
        end
      end
      S_SYNC: begin
        if (bit_en_i) begin
          if (cnt_q == SYNC_LAST) begin
            state_d = S_DATA;
            cnt_d   = 5'd0;
            w_d     = data_q[DATA_W-1];
            data_d  = data_q << 1;
          end else begin
            cnt_d  = cnt_q + 5'd1;
            w_d    = sync_q[SYNC_LEN-1];
            sync_d = sync_q << 1;
          end
        end
      end
      S_DATA: begin
        if (bit_en_i) begin
          if (cnt_q == DATA_LAST) begin
            state_d = (GAP_BITS > 0) ? S_GAP : S_IDLE;
            cnt_d   = 5'd0;
            w_d     = IDLE_LVL;
            done_d  = 1'b1;
          end else begin
            cnt_d  = cnt_q + 5'd1;
            w_d    = data_q[DATA_W-1];
            data_d = data_q << 1;
          end
        end
      end
      S_GAP: begin
        w_d = IDLE_LVL;
        if (bit_en_i) begin
          if (cnt_q == GAP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
        w_d     = IDLE_LVL;
      end
    endcase
  end

  always_comb begin
    load_ready_o = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    w_o          = w_q;
    frame_done_o = done_q;
    bit_cnt_o    = cnt_q;
  end

endmodule
